k6502_timing: RTL and testbench
===============================

K6502_TIMING -- requirements
Module: k6502_timing

Interface
REQ-001 Clocking: one clock; reset is synchronous and active-high.
REQ-002 ph0  in  1  processor clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 rdy  in  1  1 = advance; 0 = stall all state.
REQ-005 pd  in  8  pre-decode register output (opcode byte on data bus).
REQ-006 t_end  in  1  from instruction decoder: current cycle is the last body cycle.
REQ-007 ir  out  8  instruction register.
REQ-008 t  out  7  one-hot timing state; t[0]=T0 ... t[6]=T6.
REQ-009 sync  out  1  opcode-fetch cycle indicator.
REQ-010 two_cycle  out  1  registered predecode flag for the instruction in ir.
REQ-011 rst_seq  out  1  reset sequence in progress.
REQ-012 i_pc  out  1  PC increment request; drives control_signals_t.i_pc.
REQ-013 timing_err  out  1  one-cycle pulse on forced instruction termination.

Function
REQ-014 States: T0, T1 (fetch), T2..T6 (body); exactly one t bit set at all times.
REQ-015 rdy=0: state, ir, two_cycle, rst_seq hold; i_pc=0; timing_err=0.
REQ-016 T1 with rdy=1: ir<=pd; two_cycle<=predecode(pd); next T0 if predecode(pd)=1, else T2.
REQ-017 predecode(x)=1 iff x[3:0]=8 or x[3:0]=A or x[4:0]=09, or (x[7:5]>=3'b101 and x[4:0] in {00,02}).
REQ-018 Tn (n=2..5) with rdy=1: t_end=1 -> T0; t_end=0 -> Tn+1.
REQ-019 T6 with rdy=1: next T0 regardless of t_end; if t_end=0, timing_err=1 during that T0 cycle.
REQ-020 T0 with rdy=1: next T1; t_end ignored in T0 and T1.
REQ-021 Resulting cycle counts: two-cycle instruction = T1,T0; other instructions = T1,T2..Tn,T0 with 3<=length<=7.
REQ-022 sync=t[1] & ~rst_seq (combinational from registered state).
REQ-023 i_pc=t[1] & rdy & ~rst_seq.
REQ-024 rst_seq clears on the T0->T1 transition with rdy=1; never set except by reset.
REQ-025 All outputs are registered or pure functions of registers plus rdy; no path from pd or t_end to any output.

Reset
REQ-026 reset=1 at an edge, overriding rdy and all other inputs, forces: t=T2 (7'b0000100), ir=8'h00, two_cycle=0, rst_seq=1, timing_err=0.
REQ-027 reset mid-instruction (any state) gives the same result on the next cycle; no partial state retained.
REQ-028 After reset, the decoder executes the BRK body from T2 and terminates it with t_end; no special exit path exists.

Structure
REQ-029 Shared package holds the t-state index constants (T0..T6), TMAX=6, and RESET_IR=8'h00; control_signals_t remains the single control-bundle typedef.
REQ-030 Predecode is a separate combinational sub-module, k6502_predecode (8-bit in, 1-bit out), reused by the top-level decoder.
REQ-031 The state register is one-hot; no encoded counter.

Verification
REQ-032 Reset 2 cycles, rdy=1, t_end=1 on the 3rd post-reset cycle -> T2,T3,T4,T0,T1; ir=00; rst_seq=1 until T1; sync=1 only in T1.
REQ-033 T1 with pd=A9 -> ir=A9, two_cycle=1, next T0 then T1; i_pc=1 only in T1 cycles.
REQ-034 T1 with pd=AD, t_end=1 in T3 -> T1,T2,T3,T0,T1; two_cycle=0; timing_err never set.
REQ-035 T1 with pd=00, t_end held 0 -> T1..T6,T0 with timing_err=1 for that single T0 cycle only, then T1.
REQ-036 rdy=0 for 3 cycles in T1 while pd cycles 11,22,33, then rdy=1 with pd=EA -> state holds T1, i_pc=0 while stalled, ir=EA afterwards, next T0.
REQ-037 reset pulsed in T4 -> next cycle t=T2, ir=00, rst_seq=1, two_cycle=0.

Source files
------------

// File: rtl/k6502_timing_pkg.sv
// k6502_timing_pkg: shared timing-state indices, reset opcode and control bundle type
package k6502_timing_pkg;
  localparam int T0 = 0;
  localparam int T1 = 1;
  localparam int T2 = 2;
  localparam int T3 = 3;
  localparam int T4 = 4;
  localparam int T5 = 5;
  localparam int T6 = 6;
  localparam int TMAX = 6;
  localparam logic [7:0] RESET_IR = 8'h00;
  typedef struct packed {
    logic i_pc;
    logic sync;
    logic timing_err;
  } control_signals_t;
endpackage

// File: rtl/k6502_timing_if.sv
// k6502_timing_if: decoder-facing bus of the timing generator
interface k6502_timing_if;
  logic rdy;
  logic [7:0] pd;
  logic t_end;
  logic [7:0] ir;
  logic [k6502_timing_pkg::TMAX:0] t;
  logic sync;
  logic two_cycle;
  logic rst_seq;
  logic i_pc;
  logic timing_err;
  modport master (
    output rdy, pd, t_end,
    input  ir, t, sync, two_cycle, rst_seq, i_pc, timing_err
  );
  modport slave (
    input  rdy, pd, t_end,
    output ir, t, sync, two_cycle, rst_seq, i_pc, timing_err
  );
endinterface

// File: rtl/k6502_timing_predecode.sv
// k6502_predecode: flags opcodes that complete in two cycles (T1,T0)
module k6502_predecode (
  input  logic [7:0] op,
  output logic       two_cycle
);
  always_comb
    two_cycle = op[3:0] == 4'h8 || op[3:0] == 4'hA || op[4:0] == 5'h09 ||
                (op[7:5] >= 3'b101 && (op[4:0] == 5'h00 || op[4:0] == 5'h02));
endmodule

// File: rtl/k6502_timing.sv
// k6502_timing: one-hot T-state sequencer with instruction register and reset sequence
module k6502_timing
  import k6502_timing_pkg::*;
(
  input  logic           ph0,
  input  logic           reset,
  k6502_timing_if.slave  bus
);
  logic [TMAX:0] t_q, t_d;
  logic [7:0] ir_q, ir_d;
  logic two_cycle_q, two_cycle_d;
  logic rst_seq_q, rst_seq_d;
  logic timing_err_q, timing_err_d;
  logic pd_two;
  control_signals_t ctl;

  k6502_predecode u_predecode (
    .op(bus.pd),
    .two_cycle(pd_two)
  );

  always_ff @(posedge ph0) begin
    if (reset) begin
      t_q          <= (TMAX+1)'(1) << T2;
      ir_q         <= RESET_IR;
      two_cycle_q  <= 1'b0;
      rst_seq_q    <= 1'b1;
      timing_err_q <= 1'b0;
    end else begin
      t_q          <= t_d;
      ir_q         <= ir_d;
      two_cycle_q  <= two_cycle_d;
      rst_seq_q    <= rst_seq_d;
      timing_err_q <= timing_err_d;
    end
  end

  // Body states T2..T5 either end on t_end or step on; T6 always ends.
  always_comb begin
    t_d         = t_q;
    ir_d        = bus.rdy && t_q[T1] ? bus.pd : ir_q;
    two_cycle_d = bus.rdy && t_q[T1] ? pd_two : two_cycle_q;
    rst_seq_d   = bus.rdy ? rst_seq_q & ~t_q[T0] : rst_seq_q;
    timing_err_d = bus.rdy & t_q[T6] & ~bus.t_end;
    if (bus.rdy) begin
      t_d[T0]    = (t_q[T1] & pd_two) | (|t_q[T5:T2] & bus.t_end) | t_q[T6];
      t_d[T1]    = t_q[T0];
      t_d[T2]    = t_q[T1] & ~pd_two;
      t_d[T6:T3] = t_q[T5:T2] & {4{~bus.t_end}};
    end
  end

  always_comb begin
    ctl.sync       = t_q[T1] & ~rst_seq_q;
    ctl.i_pc       = t_q[T1] & ~rst_seq_q & bus.rdy;
    ctl.timing_err = timing_err_q & bus.rdy;
  end

  assign bus.t          = t_q;
  assign bus.ir         = ir_q;
  assign bus.two_cycle  = two_cycle_q;
  assign bus.rst_seq    = rst_seq_q;
  assign bus.sync       = ctl.sync;
  assign bus.i_pc       = ctl.i_pc;
  assign bus.timing_err = ctl.timing_err;
endmodule

// File: tb/tb_k6502_timing.sv
// tb_k6502_timing: vector table plus hand-built reset and predecode sweeps, scoreboarded
module tb_k6502_timing;
  typedef logic [95:0] name_t;
  typedef struct {
    logic rst, rdy, t_end;
    logic [7:0] pd;
    logic chk;
    logic [19:0] exp;
    name_t name;
  } vec_t;
  typedef struct {
    logic [19:0] v;
    name_t n;
  } sb_t;

  logic ph0 = 1'b0;
  logic reset = 1'b1;
  int n_vec = 0;
  int n_bad = 0;
  sb_t sbq[$];
  vec_t tbl[$];
  logic [7:0] ops[$];
  logic [7:0] cur_ir;
  logic cur_two;

  k6502_timing_if bus();
  k6502_timing dut (
    .ph0(ph0),
    .reset(reset),
    .bus(bus)
  );

  always #5 ph0 = ~ph0;

  function automatic logic ref_pd(input logic [7:0] x);
    logic lo;
    lo = x[4:2] == 3'b000 && !x[0];
    return x[3:0] == 4'h8 || x[3:0] == 4'hA || x[4:0] == 5'h09 || (x[7] && (x[6] || x[5]) && lo);
  endfunction

  function automatic vec_t mk(input name_t nm, input logic rst, rdy, te, input logic [7:0] pd,
                              input logic chk, input int ti, input logic [7:0] ir,
                              input logic two, rs, terr);
    vec_t v;
    logic sy;
    sy = ti == 1 && !rs;
    v.name = nm;
    v.rst = rst;
    v.rdy = rdy;
    v.t_end = te;
    v.pd = pd;
    v.chk = chk;
    v.exp = {7'(1) << ti, ir, two, rs, sy, sy && rdy, terr};
    return v;
  endfunction

  task automatic apply(input vec_t v);
    @(posedge ph0);
    #1;
    reset = v.rst;
    bus.rdy = v.rdy;
    bus.t_end = v.t_end;
    bus.pd = v.pd;
    if (v.chk) sbq.push_back('{v: v.exp, n: v.name});
  endtask

  always @(negedge ph0) begin
    if (sbq.size() > 0) begin
      sb_t e;
      logic [19:0] obs;
      e = sbq.pop_front();
      obs = {bus.t, bus.ir, bus.two_cycle, bus.rst_seq, bus.sync, bus.i_pc, bus.timing_err};
      n_vec++;
      if (obs !== e.v) begin
        n_bad++;
        $display("FAIL %0s: {t,ir,two,rs,sync,ipc,terr} got %b_%h_%b%b%b%b%b want %b_%h_%b%b%b%b%b",
                 e.n, obs[19:13], obs[12:5], obs[4], obs[3], obs[2], obs[1], obs[0],
                 e.v[19:13], e.v[12:5], e.v[4], e.v[3], e.v[2], e.v[1], e.v[0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, 0 required");
    $fatal(1);
  end

  initial begin
    bus.rdy = 1'b1;
    bus.t_end = 1'b0;
    bus.pd = 8'h00;
    tbl.push_back(mk("rst0",     1,1,0,8'h00,0,0,8'h00,0,0,0));
    tbl.push_back(mk("rst1",     1,1,0,8'h00,1,2,8'h00,0,1,0));
    tbl.push_back(mk("brk_t2",   0,1,0,8'h00,1,2,8'h00,0,1,0));
    tbl.push_back(mk("brk_t3",   0,1,0,8'h00,1,3,8'h00,0,1,0));
    tbl.push_back(mk("brk_t4",   0,1,1,8'h00,1,4,8'h00,0,1,0));
    tbl.push_back(mk("brk_t0",   0,1,0,8'h00,1,0,8'h00,0,1,0));
    tbl.push_back(mk("fetch_a9", 0,1,0,8'hA9,1,1,8'h00,0,0,0));
    tbl.push_back(mk("a9_t0",    0,1,1,8'h00,1,0,8'hA9,1,0,0));
    tbl.push_back(mk("fetch_ad", 0,1,0,8'hAD,1,1,8'hA9,1,0,0));
    tbl.push_back(mk("ad_t2",    0,1,0,8'h00,1,2,8'hAD,0,0,0));
    tbl.push_back(mk("ad_t3",    0,1,1,8'h00,1,3,8'hAD,0,0,0));
    tbl.push_back(mk("ad_t0",    0,1,0,8'h00,1,0,8'hAD,0,0,0));
    tbl.push_back(mk("fetch_00", 0,1,0,8'h00,1,1,8'hAD,0,0,0));
    for (int n = 2; n <= 6; n++) tbl.push_back(mk("long_tn", 0,1,0,8'h00,1,n,8'h00,0,0,0));
    tbl.push_back(mk("terr_t0",  0,1,0,8'h00,1,0,8'h00,0,0,1));
    tbl.push_back(mk("stall_11", 0,0,1,8'h11,1,1,8'h00,0,0,0));
    tbl.push_back(mk("stall_22", 0,0,0,8'h22,1,1,8'h00,0,0,0));
    tbl.push_back(mk("stall_33", 0,0,1,8'h33,1,1,8'h00,0,0,0));
    tbl.push_back(mk("fetch_ea", 0,1,0,8'hEA,1,1,8'h00,0,0,0));
    tbl.push_back(mk("ea_t0",    0,1,0,8'h00,1,0,8'hEA,1,0,0));
    tbl.push_back(mk("fetch_ad2",0,1,0,8'hAD,1,1,8'hEA,1,0,0));
    tbl.push_back(mk("ad2_t2",   0,1,0,8'h00,1,2,8'hAD,0,0,0));
    tbl.push_back(mk("ad2_t3",   0,1,0,8'h00,1,3,8'hAD,0,0,0));
    tbl.push_back(mk("rst_in_t4",1,1,0,8'h00,1,4,8'hAD,0,0,0));
    tbl.push_back(mk("post_rst", 0,0,1,8'h00,1,2,8'h00,0,1,0));
    tbl.push_back(mk("rs_t2",    0,1,1,8'h00,1,2,8'h00,0,1,0));
    tbl.push_back(mk("rs_t0",    0,1,0,8'h00,1,0,8'h00,0,1,0));
    tbl.push_back(mk("rs_t1",    0,1,0,8'h00,1,1,8'h00,0,0,0));
    for (int n = 2; n <= 5; n++) tbl.push_back(mk("t6end_tn", 0,1,0,8'h00,1,n,8'h00,0,0,0));
    tbl.push_back(mk("t6_tend1", 0,1,1,8'h00,1,6,8'h00,0,0,0));
    tbl.push_back(mk("t6_ok_t0", 0,1,0,8'h00,1,0,8'h00,0,0,0));
    tbl.push_back(mk("fetch_00c",0,1,0,8'h00,1,1,8'h00,0,0,0));
    for (int n = 2; n <= 6; n++) tbl.push_back(mk("mask_tn", 0,1,0,8'h00,1,n,8'h00,0,0,0));
    tbl.push_back(mk("terr_mask",0,0,0,8'h00,1,0,8'h00,0,0,0));
    tbl.push_back(mk("terr_gone",0,1,0,8'h00,1,0,8'h00,0,0,0));
    tbl.push_back(mk("rst_stall",1,0,0,8'hA9,1,1,8'h00,0,0,0));
    tbl.push_back(mk("rst_ovr",  0,1,0,8'h00,1,2,8'h00,0,1,0));
    foreach (tbl[i]) apply(tbl[i]);
    // Reset from every T-state, with rdy alternating to show reset overrides stalls.
    for (int k = 0; k <= 6; k++) begin
      apply(mk("rk_pre", 1,0,0,8'hFF,0,0,8'h00,0,0,0));
      if (k >= 2) begin
        for (int n = 2; n < k; n++) apply(mk("rk_walk", 0,1,0,8'h5A,1,n,8'h00,0,1,0));
      end else begin
        apply(mk("rk_walk", 0,1,1,8'h5A,1,2,8'h00,0,1,0));
        if (k == 1) apply(mk("rk_walk0", 0,1,0,8'h5A,1,0,8'h00,0,1,0));
      end
      apply(mk("rk_hit", 1,k[0],0,8'hA9,1,k,8'h00,0,k != 1,0));
      apply(mk("rk_after", 0,1,0,8'h00,1,2,8'h00,0,1,0));
    end
    // Predecode sweep: two-cycle opcodes return to T0, others enter the body at T2.
    ops = '{8'hA9, 8'hAD, 8'h00, 8'hEA, 8'hA0, 8'hA2, 8'hC0, 8'hE2, 8'h18, 8'h0A,
            8'h09, 8'h89, 8'h20, 8'h60, 8'hB1, 8'h40, 8'hA1, 8'hFF, 8'hE0, 8'hC2,
            8'h80, 8'h82, 8'h19, 8'h1A, 8'hD0, 8'h8A};
    for (int i = 0; i < 12; i++) ops.push_back(8'($urandom_range(0, 255)));
    apply(mk("pd_pre", 1,1,0,8'h00,0,0,8'h00,0,0,0));
    apply(mk("pd_t2",  0,1,1,8'h00,1,2,8'h00,0,1,0));
    apply(mk("pd_t0",  0,1,0,8'h00,1,0,8'h00,0,1,0));
    cur_ir = 8'h00;
    cur_two = 1'b0;
    foreach (ops[i]) begin
      apply(mk("pd_t1", 0,1,0,ops[i],1,1,cur_ir,cur_two,0,0));
      if (ref_pd(ops[i])) begin
        apply(mk("pd_two", 0,1,0,8'h00,1,0,ops[i],1,0,0));
      end else begin
        apply(mk("pd_body", 0,1,1,8'h00,1,2,ops[i],0,0,0));
        apply(mk("pd_end",  0,1,0,8'h00,1,0,ops[i],0,0,0));
      end
      cur_ir = ops[i];
      cur_two = ref_pd(ops[i]);
    end
    @(posedge ph0);
    @(posedge ph0);
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: %0d entries left, 0 required", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
